// File: rtl/nanaseg_scanner.sv
// ============================================================================
// Module   : nanaseg_scanner
// Brief    : SHOW/BLANK scan controller sharing one 7-seg decoder across digits
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nanaseg_scanner #(
  parameter int DIGITS    = 4,
  parameter int SHOW_CYC  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr_en,
  input  logic [1:0]        wr_addr,
  input  logic [3:0]        wr_data,
  output logic [3:0]        dec_out,
  output logic [DIGITS-1:0] digit_sel_n,
  output logic              frame_tick
);

  localparam int C_CNT_MAX = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
  localparam int C_CNT_W   = $clog2(C_CNT_MAX);

  localparam logic [C_CNT_W-1:0] C_SHOW_LAST  = C_CNT_W'(SHOW_CYC - 1);
  localparam logic [C_CNT_W-1:0] C_BLANK_LAST = C_CNT_W'(BLANK_CYC - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_ONE    = C_CNT_W'(1);
  localparam logic [1:0]         C_IDX_LAST   = 2'(DIGITS - 1);
  localparam logic [2:0]         C_DIGITS     = 3'(DIGITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]           dec_q, dec_d;
  logic [DIGITS-1:0]    sel_n_q, sel_n_d;
  logic                 tick_q, tick_d;
  // Storage is always four deep; entries at or above DIGITS are never written.
  logic [3:0]           digit_q [4];
  logic [3:0]           digit_d [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      digit_d[i] = digit_q[i];
    end
    if (wr_en && ({1'b0, wr_addr} < C_DIGITS)) begin
      digit_d[wr_addr] = wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        idx_d = 2'd0;
        cnt_d = '0;
        if (en) begin
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (!en) begin
          state_d = IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == C_SHOW_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      BLANK: begin
        if (!en) begin
          state_d = IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == C_BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
          idx_d   = (idx_q == C_IDX_LAST) ? 2'd0 : idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so select and code switch together.
  always_comb begin
    dec_d   = 4'hF;
    sel_n_d = '1;
    tick_d  = 1'b0;
    if (state_d == SHOW) begin
      dec_d = (state_q == SHOW) ? dec_q : digit_q[idx_d];
      for (int i = 0; i < DIGITS; i++) begin
        sel_n_d[i] = (idx_d != 2'(i));
      end
    end
    if ((state_d == BLANK) && (cnt_d == C_BLANK_LAST) && (idx_d == C_IDX_LAST)) begin
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      dec_q   <= 4'hF;
      sel_n_q <= '1;
      tick_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        digit_q[i] <= 4'hF;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      sel_n_q <= sel_n_d;
      tick_q  <= tick_d;
      for (int i = 0; i < 4; i++) begin
        digit_q[i] <= digit_d[i];
      end
    end
  end

  assign dec_out     = dec_q;
  assign digit_sel_n = sel_n_q;
  assign frame_tick  = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_nanaseg_scanner.sv
// ============================================================================
// Module   : tb_nanaseg_scanner
// Brief    : directed + random scan checks of 4-digit and 3-digit scanners
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nanaseg_scanner;

  localparam int S = 4;
  localparam int B = 2;
  localparam int F = S + B;

  logic       clk = 1'b0;
  logic       rst, en, wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] dec4, dec3;
  logic [3:0] sel4;
  logic [2:0] sel3;
  logic       tick4, tick3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  nanaseg_scanner #(.DIGITS(4), .SHOW_CYC(S), .BLANK_CYC(B)) dut4 (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dec_out(dec4), .digit_sel_n(sel4), .frame_tick(tick4)
  );

  nanaseg_scanner #(.DIGITS(3), .SHOW_CYC(S), .BLANK_CYC(B)) dut3 (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dec_out(dec3), .digit_sel_n(sel3), .frame_tick(tick3)
  );

  // Reference: position inside the frame, counted from the first SHOW cycle.
  bit         act  [2];
  int         pos  [2];
  logic [3:0] lat  [2];
  logic [3:0] regs [2][4];

  function automatic int ndig(int m);
    return (m == 0) ? 4 : 3;
  endfunction

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        act[m] = 0;
        pos[m] = 0;
        for (int k = 0; k < 4; k++) regs[m][k] = 4'hF;
      end else begin
        if (!act[m]) begin
          if (en) begin
            act[m] = 1;
            pos[m] = 0;
            lat[m] = regs[m][0];
          end
        end else if (!en) begin
          act[m] = 0;
        end else begin
          pos[m] = (pos[m] + 1) % (ndig(m) * F);
          if (pos[m] % F == 0) lat[m] = regs[m][pos[m] / F];
        end
        if (wr_en && (int'(wr_addr) < ndig(m))) regs[m][wr_addr] = wr_data;
      end
    end
  endtask

  function automatic logic [3:0] exp_sel(int m);
    logic [3:0] r;
    r = 4'hF;
    if (act[m] && (pos[m] % F < S)) r[pos[m] / F] = 1'b0;
    if (ndig(m) == 3) r[3] = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] exp_dec(int m);
    return (act[m] && (pos[m] % F < S)) ? lat[m] : 4'hF;
  endfunction

  function automatic logic exp_tick(int m);
    return act[m] && (pos[m] % F == F - 1) && (pos[m] / F == ndig(m) - 1);
  endfunction

  // Common-anode, active-low segments gfedcba; non-numerals are dark.
  function automatic logic [6:0] seg7(logic [3:0] c);
    case (c)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    chk("dec4",  {28'd0, dec4},        {28'd0, exp_dec(0)});
    chk("sel4",  {28'd0, sel4},        {28'd0, exp_sel(0)});
    chk("tick4", {31'd0, tick4},       {31'd0, exp_tick(0)});
    chk("dec3",  {28'd0, dec3},        {28'd0, exp_dec(1)});
    chk("sel3",  {28'd0, 1'b0, sel3},  {28'd0, exp_sel(1)});
    chk("tick3", {31'd0, tick3},       {31'd0, exp_tick(1)});
  endtask

  task automatic wait_sel(string tag, logic [3:0] pat, int budget);
    int n = 0;
    while (sel4 !== pat && n < budget) begin
      step();
      n++;
    end
    chk(tag, {28'd0, sel4}, {28'd0, pat});
  endtask

  task automatic write(logic [1:0] a, logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    logic [3:0] pre [4];
    int last4, last3;
    pre = '{4'd3, 4'd1, 4'd4, 4'd1};
    for (int m = 0; m < 2; m++) begin
      act[m] = 0; pos[m] = 0; lat[m] = 4'hF;
      for (int k = 0; k < 4; k++) regs[m][k] = 4'hF;
    end
    rst = 1'b1; en = 1'b1; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'd0;

    // Reset held with en=1
    for (int k = 0; k < 2; k++) begin
      step();
      chk("rst_sel",  {28'd0, sel4},  32'hF);
      chk("rst_dec",  {28'd0, dec4},  32'hF);
      chk("rst_tick", {31'd0, tick4}, 32'h0);
    end
    rst = 1'b0;
    step();
    chk("first_show_sel", {28'd0, sel4}, 32'hE);
    chk("first_show_dec", {28'd0, dec4}, 32'hF);
    en = 1'b0;
    step();
    chk("idle_dark", {28'd0, sel4}, 32'hF);

    // Preload 3,1,4,1 and scan
    for (int k = 0; k < 4; k++) write(2'(k), pre[k]);
    en = 1'b1;
    step();
    chk("t2_d0_sel", {28'd0, sel4}, 32'hE);
    chk("t2_d0_dec", {28'd0, dec4}, 32'h3);

    // Mid-show write to the digit being shown
    write(2'd0, 4'd7);
    chk("t3_hold", {28'd0, dec4}, 32'h3);
    last4 = -1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (tick4) begin
        if (last4 >= 0) chk("t2_tick_period", cyc - last4, 32'd24);
        last4 = cyc;
      end
    end
    wait_sel("t3_wait_d0", 4'hE, 30);
    chk("t3_new_code", {28'd0, dec4}, 32'h7);

    // Address 3 is out of range for the 3-digit scanner
    write(2'd3, 4'd5);
    last3 = -1;
    for (int k = 0; k < 45; k++) begin
      step();
      if (tick3) begin
        if (last3 >= 0) chk("t4_tick3_period", cyc - last3, 32'd18);
        last3 = cyc;
      end
    end

    // Drop enable in the third cycle of digit 2's SHOW
    wait_sel("t5_wait_d2", 4'hB, 40);
    step();
    step();
    en = 1'b0;
    step();
    chk("t5_dark_sel", {28'd0, sel4}, 32'hF);
    chk("t5_dark_dec", {28'd0, dec4}, 32'hF);
    step();
    en = 1'b1;
    step();
    chk("t5_restart", {28'd0, sel4}, 32'hE);
    for (int k = 0; k < S - 1; k++) begin
      step();
      chk("t5_full_show", {28'd0, sel4}, 32'hE);
    end
    step();
    chk("t5_blank_after", {28'd0, sel4}, 32'hF);

    // Blank code, then reset in the middle of a BLANK
    write(2'd1, 4'hA);
    wait_sel("t6_wait_d1", 4'hD, 40);
    chk("t6_code_a", {28'd0, dec4}, 32'hA);
    chk("t6_seg_off", {25'd0, seg7(dec4)}, 32'h7F);
    wait_sel("t6_wait_blank", 4'hF, 10);
    rst = 1'b1;
    step();
    chk("t6_rst_sel", {28'd0, sel4}, 32'hF);
    chk("t6_rst_dec", {28'd0, dec4}, 32'hF);
    rst = 1'b0;
    step();
    chk("t6_regs_cleared", {28'd0, dec4}, 32'hF);

    // Random traffic against the reference
    for (int k = 0; k < 900; k++) begin
      rst = ($urandom % 300 == 0);
      if ($urandom % 50 == 0) en = 1'b0;
      else if (!en && ($urandom % 3 == 0)) en = 1'b1;
      wr_en   = ($urandom % 3 == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 4'($urandom_range(0, 15));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nanaseg_scanner.md
Name: nanaseg_scanner

Overview:
Time-multiplexed scan controller for a multi-digit common-anode 7-segment display on the gridlock board. It holds one 4-bit code per digit, written by the CPU-side I/O logic, and shares a single nanaseg decoder across all digits. It does this by sequencing the decoder input and the active-low digit enables through SHOW/BLANK phases. A BLANK gap between digits suppresses ghosting. Code 4'hF drives the decoder to all-segments-off.

Parameters:
DIGITS, 4, number of digits scanned; legal range 1..4.
SHOW_CYC, 50000, clocks each digit is enabled; must be ≥2.
BLANK_CYC, 500, clocks all digits are off between consecutive digits; must be ≥1.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
en  input  1  scan enable; 0 forces display dark
wr_en  input  1  write strobe for a digit register, single-cycle
wr_addr  input  2  digit index to write; 0 is the rightmost digit
wr_data  input  4  code to store; 0..9 are numerals, others blank through the decoder
dec_out  output  4  code presented to the shared decoder input
digit_sel_n  output  DIGITS  one-hot-low digit enable
frame_tick  output  1  one-cycle pulse at the end of the last digit's BLANK phase

Behaviour:
- Reset takes effect on a clk edge with rst=1, regardless of en or wr_en.
  - All digit registers go to 4'hF, state to IDLE, idx to 0, counter to 0.
  - dec_out=4'hF, digit_sel_n=all ones, frame_tick=0.
- Writes:
  - If wr_en=1 and wr_addr<DIGITS, the register is updated at that edge. wr_addr≥DIGITS is ignored.
  - Writes are accepted in every state. There is no backpressure or busy signal.
- Display latch:
  - dec_out shows a value latched from the digit register on entry to SHOW.
  - A write to the currently shown digit does not change dec_out until that digit's next SHOW.
  - A write on the same edge as SHOW entry is not visible until the following SHOW. The pre-write value is latched.
- FSM states: IDLE, SHOW, BLANK.
  - IDLE: digit_sel_n all ones, dec_out=4'hF, idx=0, counter=0. If en=1, go to SHOW on the next edge.
  - SHOW:
    - digit_sel_n[idx]=0, all other bits 1. dec_out=latched code.
    - Lasts exactly SHOW_CYC cycles, counter 0..SHOW_CYC-1, then goes to BLANK with counter=0.
  - BLANK:
    - digit_sel_n all ones, dec_out=4'hF.
    - Lasts exactly BLANK_CYC cycles, then idx advances.
    - idx wraps from DIGITS-1 to 0, and frame_tick=1 for the last cycle of that BLANK.
    - Then enters SHOW for the new idx.
- Outputs are registered. digit_sel_n and dec_out change on the same edge, so no cycle has a digit enabled with a stale code.
- en=0 in SHOW or BLANK: the next edge goes to IDLE, the display goes dark that cycle, and idx resets to 0. Re-enable restarts at digit 0.
- DIGITS=1: the sequence is SHOW(0)→BLANK→SHOW(0). frame_tick pulses every frame.
- The counter is sized to $clog2(max(SHOW_CYC,BLANK_CYC)). No wrap occurs beyond terminal counts.
- Frame period = DIGITS*(SHOW_CYC+BLANK_CYC) cycles. The first frame after IDLE adds 1 cycle.

Test Plan:
1. Reset: rst=1 for 2 cycles with en=1 → dec_out=F, digit_sel_n=1111, frame_tick=0. The first SHOW occurs only after rst drops.
2. Nominal scan with SHOW_CYC=4, BLANK_CYC=2, DIGITS=4, en=1:
   - Preload digits to 3,1,4,1 (addr0..3).
   - Required sequence: digit_sel_n=1110 with dec_out=3 for 4 cycles, then 1111/F for 2 cycles, then 1101/1, 1011/4, 0111/1.
   - frame_tick pulses exactly once every 24 cycles, on the last BLANK cycle after digit 3.
3. Mid-show write: write 7 to addr0 during digit 0's SHOW → dec_out stays 3 through that SHOW. The next frame's digit 0 shows 7.
4. Illegal address with DIGITS=3: write wr_addr=3, data=5 → no register changes, and the scan never enables digit_sel_n bit 3 (it does not exist).
5. Enable drop: deassert en in the third cycle of digit 2's SHOW → next cycle digit_sel_n=all ones, dec_out=F. Reassert en → SHOW restarts at digit 0 with a full SHOW_CYC.
6. Blank code and reset mid-operation:
   - Write A to addr1 → dec_out=A during digit 1's SHOW, and the decoder output is 1111111.
   - Assert rst mid-BLANK → all registers return to F and state to IDLE on that edge.
